// File: rtl/window_address_gen.sv
// KxK sliding-window tap address generator, one tap per valid/ready beat.
// Optional macro WINDOW_PAD_EN enables same-size zero padding.

module window_address_gen #(
    parameter int IMG_WIDTH  = 80,
    parameter int IMG_HEIGHT = 60,
    parameter int KERNEL     = 3,
    parameter int STRIDE     = 1,
    parameter int ADDR_W     = 13,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [5:0]        out_tap,
    output logic              out_last_win,
    output logic              out_last_frame,
    output logic              out_pad,
    output logic              busy,
    output logic              done
);

`ifdef WINDOW_PAD_EN
    localparam int PAD = (KERNEL - 1) / 2;
`else
    localparam int PAD = 0;
`endif
    localparam int MAXD = ((IMG_WIDTH > IMG_HEIGHT) ? IMG_WIDTH : IMG_HEIGHT) + KERNEL;
    localparam int CW   = $clog2(MAXD + 1) + 2;

`ifdef WINDOW_PAD_EN
    typedef logic signed [CW-1:0] cnt_t;
`else
    typedef logic [CW-1:0] cnt_t;
`endif

    // Last origin actually reached by the stride walk, not just the bound
    localparam int R0_LAST_I = ((IMG_HEIGHT - KERNEL + 2 * PAD) / STRIDE) * STRIDE - PAD;
    localparam int C0_LAST_I = ((IMG_WIDTH - KERNEL + 2 * PAD) / STRIDE) * STRIDE - PAD;

    localparam cnt_t ORG_FIRST = cnt_t'(-PAD);
    localparam cnt_t R0_LAST   = cnt_t'(R0_LAST_I);
    localparam cnt_t C0_LAST   = cnt_t'(C0_LAST_I);
    localparam cnt_t K_LAST    = cnt_t'(KERNEL - 1);
    localparam cnt_t STEP      = cnt_t'(STRIDE);
    localparam cnt_t ONE       = cnt_t'(1);

    // Row offsets are kept modulo 2^ADDR_W; negative padded rows wrap harmlessly
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ROW_A     = ADDR_W'(IMG_WIDTH);
    localparam logic [ADDR_W-1:0] SROW_A    = ADDR_W'(STRIDE * IMG_WIDTH);
    localparam logic [ADDR_W-1:0] OROW_INIT = ADDR_W'(-PAD * IMG_WIDTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state_q, state_d;

    cnt_t r0_q, r0_d, c0_q, c0_d, kr_q, kr_d, kc_q, kc_d;
    cnt_t n_r0, n_c0, n_kr, n_kc;
    cnt_t col_d;

    logic [ADDR_W-1:0] orow_q, orow_d, trow_q, trow_d;
    logic [ADDR_W-1:0] n_orow, n_trow;
    logic [5:0]        tap_q, tap_d, n_tap;

    logic              out_valid_q, valid_d;
    logic [ADDR_W-1:0] out_addr_q, addr_d;
    logic              out_last_win_q, last_win_d;
    logic              out_last_frame_q, last_frame_d;
    logic              done_q, done_d;
    logic              fire;
    logic              pad_d;

`ifdef WINDOW_PAD_EN
    localparam cnt_t ZERO  = '0;
    localparam cnt_t H_LIM = cnt_t'(IMG_HEIGHT);
    localparam cnt_t W_LIM = cnt_t'(IMG_WIDTH);

    cnt_t row_d;
    logic out_pad_q;
`endif

    assign fire = out_valid_q & out_ready;

    // Successor of the current tap: kc fastest, then kr, then c0, then r0
    always_comb begin
        n_r0   = r0_q;
        n_c0   = c0_q;
        n_kr   = kr_q;
        n_kc   = kc_q;
        n_orow = orow_q;
        n_trow = trow_q;
        n_tap  = tap_q + 6'd1;
        if (kc_q != K_LAST) begin
            n_kc = kc_q + ONE;
        end else begin
            n_kc = '0;
            if (kr_q != K_LAST) begin
                n_kr   = kr_q + ONE;
                n_trow = trow_q + ROW_A;
            end else begin
                n_kr  = '0;
                n_tap = '0;
                if (c0_q != C0_LAST) begin
                    n_c0   = c0_q + STEP;
                    n_trow = orow_q;
                end else begin
                    n_c0   = ORG_FIRST;
                    n_r0   = r0_q + STEP;
                    n_orow = orow_q + SROW_A;
                    n_trow = orow_q + SROW_A;
                end
            end
        end
    end

    // Control: frame start, advance on accept, finish or abort
    always_comb begin
        state_d = state_q;
        r0_d    = r0_q;
        c0_d    = c0_q;
        kr_d    = kr_q;
        kc_d    = kc_q;
        orow_d  = orow_q;
        trow_d  = trow_q;
        tap_d   = tap_q;
        valid_d = out_valid_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = RUN;
                    valid_d = 1'b1;
                    r0_d    = ORG_FIRST;
                    c0_d    = ORG_FIRST;
                    kr_d    = '0;
                    kc_d    = '0;
                    orow_d  = OROW_INIT;
                    trow_d  = OROW_INIT;
                    tap_d   = '0;
                end
            end
            RUN: begin
                if (abort || (fire && out_last_frame_q)) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    done_d  = !abort;
                    r0_d    = '0;
                    c0_d    = '0;
                    kr_d    = '0;
                    kc_d    = '0;
                    orow_d  = '0;
                    trow_d  = '0;
                    tap_d   = '0;
                end else if (fire) begin
                    r0_d   = n_r0;
                    c0_d   = n_c0;
                    kr_d   = n_kr;
                    kc_d   = n_kc;
                    orow_d = n_orow;
                    trow_d = n_trow;
                    tap_d  = n_tap;
                end
            end
            default: ;
        endcase
    end

    // Output beat derived from the next counter state
    always_comb begin
        col_d = c0_d + kc_d;
`ifdef WINDOW_PAD_EN
        row_d = r0_d + kr_d;
        pad_d = valid_d & ((row_d < ZERO) | (row_d >= H_LIM) |
                           (col_d < ZERO) | (col_d >= W_LIM));
`else
        pad_d = 1'b0;
`endif
        addr_d       = '0;
        last_win_d   = 1'b0;
        last_frame_d = 1'b0;
        if (valid_d) begin
            addr_d       = pad_d ? BASE : BASE + trow_d + ADDR_W'(col_d);
            last_win_d   = (kr_d == K_LAST) && (kc_d == K_LAST);
            last_frame_d = last_win_d && (r0_d == R0_LAST) && (c0_d == C0_LAST);
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            r0_q             <= '0;
            c0_q             <= '0;
            kr_q             <= '0;
            kc_q             <= '0;
            orow_q           <= '0;
            trow_q           <= '0;
            tap_q            <= '0;
            out_valid_q      <= 1'b0;
            out_addr_q       <= '0;
            out_last_win_q   <= 1'b0;
            out_last_frame_q <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            r0_q             <= r0_d;
            c0_q             <= c0_d;
            kr_q             <= kr_d;
            kc_q             <= kc_d;
            orow_q           <= orow_d;
            trow_q           <= trow_d;
            tap_q            <= tap_d;
            out_valid_q      <= valid_d;
            out_addr_q       <= addr_d;
            out_last_win_q   <= last_win_d;
            out_last_frame_q <= last_frame_d;
            done_q           <= done_d;
        end
    end

`ifdef WINDOW_PAD_EN
    // Padding flag register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_pad_q <= 1'b0;
        end else begin
            out_pad_q <= pad_d;
        end
    end

    assign out_pad = out_pad_q;
`else
    assign out_pad = pad_d;
`endif

    assign out_valid      = out_valid_q;
    assign out_addr       = out_addr_q;
    assign out_tap        = tap_q;
    assign out_last_win   = out_last_win_q;
    assign out_last_frame = out_last_frame_q;
    assign busy           = (state_q == RUN);
    assign done           = done_q;

endmodule
